riscv_imm_arbiter: RTL and testbench
====================================

Name: riscv_imm_arbiter

Overview:
Shares one riscv_extend immediate generator between two requesters: port 0 is the decode stage and port 1 is the branch-target pre-decoder. Each cycle the block grants at most one requester using round-robin priority. It drives the granted instruction and immsrc onto the shared extender, which is combinational. It captures the extender result into a one-entry response buffer per requester, with a valid/ready handshake on both the request and response sides.

Parameters:
XLEN, 64, width of the sign-extended immediate and of the response data.

Ports:
i_riscv_immarb_clk  input  1  clock; all state updates on the rising edge
i_riscv_immarb_rst_n  input  1  synchronous, active-low reset
i_riscv_immarb_req0_valid  input  1  requester 0 has a request
o_riscv_immarb_req0_ready  output  1  requester 0 request accepted this cycle
i_riscv_immarb_req0_inst  input  25  requester 0 instruction bits [31:7]
i_riscv_immarb_req0_immsrc  input  3  requester 0 immediate format
i_riscv_immarb_req1_valid / o_riscv_immarb_req1_ready / i_riscv_immarb_req1_inst / i_riscv_immarb_req1_immsrc  as requester 0, for port 1
o_riscv_immarb_rsp0_valid  output  1  response buffer 0 holds a result
i_riscv_immarb_rsp0_ready  input  1  consumer 0 takes the result
o_riscv_immarb_rsp0_simm  output  XLEN  result for requester 0
o_riscv_immarb_rsp1_valid / i_riscv_immarb_rsp1_ready / o_riscv_immarb_rsp1_simm  as above, for port 1
o_riscv_immarb_ext_immsrc  output  3  to the shared extender
o_riscv_immarb_ext_inst  output  25  to the shared extender
i_riscv_immarb_ext_simm  input  XLEN  result from the shared extender, same cycle

Behaviour:
- Single clock, synchronous active-low reset.
- Reset values:
  - rspN_valid = 0, rspN_simm = 0.
  - Round-robin pointer last_grant = 1, so port 0 wins the first contention.
- Slot availability: slotN_free = !rspN_valid || i_riscv_immarb_rspN_ready. A buffer drained in a cycle may be refilled in that same cycle.
- Eligibility: eligN = reqN_valid && slotN_free.
- Grant, combinational:
  - If both ports are eligible, grant the port != last_grant.
  - If only one is eligible, grant it.
  - Otherwise grant none.
- reqN_ready = grantN. Ready never asserts without valid. At most one ready is high per cycle.
- Extender drive:
  - ext_inst / ext_immsrc = the granted port's inst / immsrc.
  - With no grant, both are 0.
- Capture and latency:
  - On a clock edge with grantN, rspN_simm <= ext_simm and rspN_valid <= 1.
  - Accept at edge N gives the response visible from cycle N+1. Latency is 1 cycle.
- Hold: while rspN_valid && !rspN_ready, rspN_simm and rspN_valid hold stable.
- Drain: on an edge with rspN_ready && !grantN, rspN_valid <= 0. The simm value holds its last value.
- Pointer update: last_grant <= granted port on every grant. It holds when there is no grant.
- Fairness:
  - With both ports continuously eligible, grants alternate 0,1,0,1.
  - Maximum wait for an eligible port is 1 cycle.
- Backpressure isolation: a full, undrained buffer on one port never blocks grants to the other port.
- Unused immsrc codes (5–7) pass through unchanged. The extender returns 0, and that 0 is buffered as a normal response.
- Request inputs are sampled only in the grant cycle. Changing inst while valid && !ready is permitted.
- Reset mid-operation:
  - Buffered responses are discarded. Both rsp_valid go to 0 in the cycle after rst_n is sampled low.
  - Pending requests are not granted while rst_n = 0 (all ready = 0).
  - last_grant returns to 1.
- No combinational path from rspN_ready to rspN_valid.
- There are paths from reqN_valid and rspN_ready to reqN_ready and the ext_* outputs. Callers must register their side.

Test Plan:
- Reset, then req0 only with inst[31:7] of 0xFFF00093 (addi x1,x0,-1) and immsrc=000 -> req0_ready=1 in the same cycle; next cycle rsp0_valid=1 and rsp0_simm=0xFFFF_FFFF_FFFF_FFFF; req1_ready stays 0.
- Both ports valid from reset with rsp_ready=1: req0 = lui 0x12345 (0x123450B7, immsrc=001), req1 = I-type with immediate 0x7FF -> grants alternate 0,1,0,1. Responses are 0x0000_0000_1234_5000 and 0x0000_0000_0000_07FF.
- Backpressure: hold rsp0_ready=0 after one port-0 response; req0 and req1 stay valid -> req0_ready stays 0 and rsp0_simm is stable. Port 1 is granted every cycle. Raising rsp0_ready regrants port 0 in that same cycle.
- Same-cycle drain and refill on port 0 (rsp0_valid=1, rsp0_ready=1, req0_valid=1): send a B-type with immediate -4, then a J-type with immediate 0x800 -> rsp0_valid stays 1 continuously. simm updates from 0xFFFF_FFFF_FFFF_FFFC to 0x0000_0000_0000_0800 with no bubble.
- Illegal immsrc=111 on req1 -> granted normally; rsp1_simm = 0 one cycle later.
- Assert rst_n=0 for one cycle while both response buffers are full and both requests are pending -> the next cycle has both rsp_valid=0 and all ready=0. After release, port 0 wins the first contention.

Source files
------------

// File: rtl/riscv_imm_arbiter.sv
// Round-robin arbiter that shares one combinational immediate extender between
// two requesters, with a one-entry response buffer per requester.
module riscv_imm_arbiter #(
  parameter int XLEN = 64
) (
  input  logic            i_riscv_immarb_clk,
  input  logic            i_riscv_immarb_rst_n,
  input  logic            i_riscv_immarb_req0_valid,
  output logic            o_riscv_immarb_req0_ready,
  input  logic [24:0]     i_riscv_immarb_req0_inst,
  input  logic [2:0]      i_riscv_immarb_req0_immsrc,
  input  logic            i_riscv_immarb_req1_valid,
  output logic            o_riscv_immarb_req1_ready,
  input  logic [24:0]     i_riscv_immarb_req1_inst,
  input  logic [2:0]      i_riscv_immarb_req1_immsrc,
  output logic            o_riscv_immarb_rsp0_valid,
  input  logic            i_riscv_immarb_rsp0_ready,
  output logic [XLEN-1:0] o_riscv_immarb_rsp0_simm,
  output logic            o_riscv_immarb_rsp1_valid,
  input  logic            i_riscv_immarb_rsp1_ready,
  output logic [XLEN-1:0] o_riscv_immarb_rsp1_simm,
  output logic [2:0]      o_riscv_immarb_ext_immsrc,
  output logic [24:0]     o_riscv_immarb_ext_inst,
  input  logic [XLEN-1:0] i_riscv_immarb_ext_simm
);

  logic            r_last_grant;
  logic            r_rsp0_valid;
  logic            r_rsp1_valid;
  logic [XLEN-1:0] r_rsp0_simm;
  logic [XLEN-1:0] r_rsp1_simm;

  logic w_elig0;
  logic w_elig1;
  logic w_grant0;
  logic w_grant1;

  // Grants are suppressed while reset is asserted so no request is lost.
  assign w_elig0 = i_riscv_immarb_rst_n && i_riscv_immarb_req0_valid &&
                   (!r_rsp0_valid || i_riscv_immarb_rsp0_ready);
  assign w_elig1 = i_riscv_immarb_rst_n && i_riscv_immarb_req1_valid &&
                   (!r_rsp1_valid || i_riscv_immarb_rsp1_ready);

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (w_elig0 && w_elig1) begin
      w_grant0 = r_last_grant;
      w_grant1 = !r_last_grant;
    end else begin
      w_grant0 = w_elig0;
      w_grant1 = w_elig1;
    end
  end

  always_comb begin
    o_riscv_immarb_ext_inst   = '0;
    o_riscv_immarb_ext_immsrc = '0;
    if (w_grant0) begin
      o_riscv_immarb_ext_inst   = i_riscv_immarb_req0_inst;
      o_riscv_immarb_ext_immsrc = i_riscv_immarb_req0_immsrc;
    end else if (w_grant1) begin
      o_riscv_immarb_ext_inst   = i_riscv_immarb_req1_inst;
      o_riscv_immarb_ext_immsrc = i_riscv_immarb_req1_immsrc;
    end
  end

  always_ff @(posedge i_riscv_immarb_clk) begin
    if (!i_riscv_immarb_rst_n) begin
      r_last_grant <= 1'b1;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_simm  <= '0;
      r_rsp1_simm  <= '0;
    end else begin
      if (w_grant0) begin
        r_rsp0_valid <= 1'b1;
        r_rsp0_simm  <= i_riscv_immarb_ext_simm;
      end else if (i_riscv_immarb_rsp0_ready) begin
        r_rsp0_valid <= 1'b0;
      end
      if (w_grant1) begin
        r_rsp1_valid <= 1'b1;
        r_rsp1_simm  <= i_riscv_immarb_ext_simm;
      end else if (i_riscv_immarb_rsp1_ready) begin
        r_rsp1_valid <= 1'b0;
      end
      if (w_grant0) begin
        r_last_grant <= 1'b0;
      end else if (w_grant1) begin
        r_last_grant <= 1'b1;
      end
    end
  end

  assign o_riscv_immarb_req0_ready = w_grant0;
  assign o_riscv_immarb_req1_ready = w_grant1;
  assign o_riscv_immarb_rsp0_valid = r_rsp0_valid;
  assign o_riscv_immarb_rsp1_valid = r_rsp1_valid;
  assign o_riscv_immarb_rsp0_simm  = r_rsp0_simm;
  assign o_riscv_immarb_rsp1_simm  = r_rsp1_simm;

endmodule

// File: tb/tb_riscv_imm_arbiter.sv
// Bench for riscv_imm_arbiter: directed scenarios plus a randomized run against
// a transaction-level model; a behavioural extender closes the ext_* loop.
module tb_riscv_imm_arbiter;
  localparam int XLEN = 64;
  localparam logic [31:0] ADDI  = 32'hFFF00093;
  localparam logic [31:0] LUI   = 32'h123450B7;
  localparam logic [31:0] ITYPE = 32'h7FF00093;
  localparam logic [31:0] BEQ   = 32'hFE000EE3;
  localparam logic [31:0] JAL   = 32'h0010006F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r0v = 1'b0, r1v = 1'b0, p0r = 1'b0, p1r = 1'b0;
  logic [24:0] r0i = '0, r1i = '0;
  logic [2:0]  r0s = '0, r1s = '0;
  logic ready0, ready1, rv0, rv1;
  logic [XLEN-1:0] simm0, simm1, ext_simm;
  logic [2:0]  ext_immsrc;
  logic [24:0] ext_inst;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Extender encoding: 0 I, 1 U, 2 S, 3 B, 4 J, others return zero.
  function automatic logic [63:0] ext_fn(input logic [24:0] i25, input logic [2:0] s);
    logic [31:0] f;
    f = {i25, 7'b0};
    case (s)
      3'd0: return {{52{f[31]}}, f[31:20]};
      3'd1: return {{32{f[31]}}, f[31:12], 12'b0};
      3'd2: return {{52{f[31]}}, f[31:25], f[11:7]};
      3'd3: return {{51{f[31]}}, f[31], f[7], f[30:25], f[11:8], 1'b0};
      3'd4: return {{43{f[31]}}, f[31], f[19:12], f[20], f[30:21], 1'b0};
      default: return 64'd0;
    endcase
  endfunction

  assign ext_simm = ext_fn(ext_inst, ext_immsrc);

  riscv_imm_arbiter #(.XLEN(XLEN)) dut (
    .i_riscv_immarb_clk(clk),
    .i_riscv_immarb_rst_n(rst_n),
    .i_riscv_immarb_req0_valid(r0v),
    .o_riscv_immarb_req0_ready(ready0),
    .i_riscv_immarb_req0_inst(r0i),
    .i_riscv_immarb_req0_immsrc(r0s),
    .i_riscv_immarb_req1_valid(r1v),
    .o_riscv_immarb_req1_ready(ready1),
    .i_riscv_immarb_req1_inst(r1i),
    .i_riscv_immarb_req1_immsrc(r1s),
    .o_riscv_immarb_rsp0_valid(rv0),
    .i_riscv_immarb_rsp0_ready(p0r),
    .o_riscv_immarb_rsp0_simm(simm0),
    .o_riscv_immarb_rsp1_valid(rv1),
    .i_riscv_immarb_rsp1_ready(p1r),
    .o_riscv_immarb_rsp1_simm(simm1),
    .o_riscv_immarb_ext_immsrc(ext_immsrc),
    .o_riscv_immarb_ext_inst(ext_inst),
    .i_riscv_immarb_ext_simm(ext_simm)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r0v = 0; r1v = 0; p0r = 0; p1r = 0;
    r0i = '0; r1i = '0; r0s = '0; r1s = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    r0v = 1; r1v = 1; p0r = 1; p1r = 1;
    #2;
    checks++; if (ready0 !== 1'b0 || ready1 !== 1'b0) begin errors++;
      $display("FAIL reset_ready got %0b%0b exp 00", ready0, ready1); end
    checks++; if (ext_inst !== 25'd0 || ext_immsrc !== 3'd0) begin errors++;
      $display("FAIL reset_ext got %h/%0d exp 0/0", ext_inst, ext_immsrc); end
    tick();
    checks++; if (rv0 !== 1'b0 || rv1 !== 1'b0) begin errors++;
      $display("FAIL reset_rsp_valid got %0b%0b exp 00", rv0, rv1); end
    checks++; if (simm0 !== '0 || simm1 !== '0) begin errors++;
      $display("FAIL reset_simm got %h %h exp 0", simm0, simm1); end
    rst_n = 1;
    idle();
  endtask

  task automatic test_single();
    do_reset();
    r0v = 1; r0i = ADDI[31:7]; r0s = 3'd0;
    #2;
    checks++; if (ready0 !== 1'b1 || ready1 !== 1'b0) begin errors++;
      $display("FAIL single_ready got %0b%0b exp 10", ready0, ready1); end
    checks++; if (ext_inst !== ADDI[31:7]) begin errors++;
      $display("FAIL single_ext_inst got %h exp %h", ext_inst, ADDI[31:7]); end
    tick();
    r0v = 0;
    checks++; if (rv0 !== 1'b1 || simm0 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++;
      $display("FAIL single_rsp got %0b/%h exp 1/ffffffffffffffff", rv0, simm0); end
    checks++; if (rv1 !== 1'b0) begin errors++;
      $display("FAIL single_rsp1_valid got %0b exp 0", rv1); end
    p0r = 1;
    tick();
    checks++; if (rv0 !== 1'b0 || simm0 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++;
      $display("FAIL single_drain got %0b/%h exp 0/ffffffffffffffff", rv0, simm0); end
    idle();
  endtask

  task automatic test_alternate();
    do_reset();
    r0v = 1; r0i = LUI[31:7];   r0s = 3'd1;
    r1v = 1; r1i = ITYPE[31:7]; r1s = 3'd0;
    p0r = 1; p1r = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++; if (ready0 !== ((i % 2) == 0) || ready1 !== ((i % 2) == 1)) begin errors++;
        $display("FAIL alt_grant cycle %0d got %0b%0b exp port %0d", i, ready0, ready1, i % 2); end
      tick();
      if ((i % 2) == 0) begin
        checks++; if (rv0 !== 1'b1 || simm0 !== 64'h0000_0000_1234_5000) begin errors++;
          $display("FAIL alt_rsp0 cycle %0d got %0b/%h exp 1/0000000012345000", i, rv0, simm0); end
      end else begin
        checks++; if (rv1 !== 1'b1 || simm1 !== 64'h0000_0000_0000_07FF) begin errors++;
          $display("FAIL alt_rsp1 cycle %0d got %0b/%h exp 1/00000000000007ff", i, rv1, simm1); end
      end
    end
    idle();
  endtask

  task automatic test_backpressure();
    do_reset();
    r0v = 1; r0i = LUI[31:7];   r0s = 3'd1;
    r1v = 1; r1i = ITYPE[31:7]; r1s = 3'd0;
    p0r = 1; p1r = 1;
    tick();
    p0r = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (ready0 !== 1'b0 || ready1 !== 1'b1) begin errors++;
        $display("FAIL bp_grant cycle %0d got %0b%0b exp 01", i, ready0, ready1); end
      tick();
      checks++; if (rv0 !== 1'b1 || simm0 !== 64'h0000_0000_1234_5000) begin errors++;
        $display("FAIL bp_hold cycle %0d got %0b/%h exp 1/0000000012345000", i, rv0, simm0); end
    end
    p0r = 1;
    #2;
    checks++; if (ready0 !== 1'b1 || ready1 !== 1'b0) begin errors++;
      $display("FAIL bp_regrant got %0b%0b exp 10", ready0, ready1); end
    tick();
    idle();
  endtask

  task automatic test_drain_refill();
    do_reset();
    r0v = 1; r0i = BEQ[31:7]; r0s = 3'd3;
    tick();
    checks++; if (rv0 !== 1'b1 || simm0 !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++;
      $display("FAIL refill_first got %0b/%h exp 1/fffffffffffffffc", rv0, simm0); end
    r0i = JAL[31:7]; r0s = 3'd4; p0r = 1;
    #2;
    checks++; if (ready0 !== 1'b1) begin errors++;
      $display("FAIL refill_ready got %0b exp 1", ready0); end
    tick();
    checks++; if (rv0 !== 1'b1 || simm0 !== 64'h0000_0000_0000_0800) begin errors++;
      $display("FAIL refill_second got %0b/%h exp 1/0000000000000800", rv0, simm0); end
    idle();
  endtask

  task automatic test_illegal();
    do_reset();
    r1v = 1; r1i = LUI[31:7]; r1s = 3'd1; p1r = 1;
    tick();
    r1i = 25'h1ABCDEF; r1s = 3'd7;
    #2;
    checks++; if (ready1 !== 1'b1 || ext_immsrc !== 3'd7) begin errors++;
      $display("FAIL illegal_grant got %0b/%0d exp 1/7", ready1, ext_immsrc); end
    tick();
    checks++; if (rv1 !== 1'b1 || simm1 !== 64'd0) begin errors++;
      $display("FAIL illegal_rsp got %0b/%h exp 1/0", rv1, simm1); end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    r0v = 1; r0i = LUI[31:7];   r0s = 3'd1;
    r1v = 1; r1i = ITYPE[31:7]; r1s = 3'd0;
    tick();
    tick();
    checks++; if (rv0 !== 1'b1 || rv1 !== 1'b1) begin errors++;
      $display("FAIL midrst_full got %0b%0b exp 11", rv0, rv1); end
    rst_n = 0; p0r = 1; p1r = 1;
    #2;
    checks++; if (ready0 !== 1'b0 || ready1 !== 1'b0) begin errors++;
      $display("FAIL midrst_ready got %0b%0b exp 00", ready0, ready1); end
    tick();
    checks++; if (rv0 !== 1'b0 || rv1 !== 1'b0) begin errors++;
      $display("FAIL midrst_valid got %0b%0b exp 00", rv0, rv1); end
    rst_n = 1;
    #2;
    checks++; if (ready0 !== 1'b1 || ready1 !== 1'b0) begin errors++;
      $display("FAIL midrst_first got %0b%0b exp 10", ready0, ready1); end
    tick();
    idle();
  endtask

  // Model: each port owns a one-deep mailbox; contention goes to whichever port
  // was not the most recent winner.
  task automatic test_random();
    logic        mv[2];
    logic [63:0] mval[2];
    int          recent;
    int          win;
    logic        want[2];
    logic [24:0] exp_inst;
    do_reset();
    mv[0] = 0; mv[1] = 0; mval[0] = '0; mval[1] = '0; recent = 1;
    for (int c = 0; c < 400; c++) begin
      r0v = ($urandom_range(0, 9) < 7); r1v = ($urandom_range(0, 9) < 7);
      p0r = ($urandom_range(0, 9) < 5); p1r = ($urandom_range(0, 9) < 5);
      r0i = 25'($urandom); r1i = 25'($urandom);
      r0s = 3'($urandom_range(0, 7)); r1s = 3'($urandom_range(0, 7));
      want[0] = r0v && (!mv[0] || p0r);
      want[1] = r1v && (!mv[1] || p1r);
      if (want[0] && want[1]) win = 1 - recent;
      else if (want[0])       win = 0;
      else if (want[1])       win = 1;
      else                    win = -1;
      exp_inst = (win == 0) ? r0i : (win == 1) ? r1i : 25'd0;
      #2;
      checks++; if (ready0 !== (win == 0) || ready1 !== (win == 1)) begin errors++;
        $display("FAIL rand_grant cycle %0d got %0b%0b exp winner %0d", c, ready0, ready1, win); end
      checks++; if (ext_inst !== exp_inst) begin errors++;
        $display("FAIL rand_ext_inst cycle %0d got %h exp %h", c, ext_inst, exp_inst); end
      if (win == 0) begin mv[0] = 1; mval[0] = ext_fn(r0i, r0s); end
      else if (p0r) mv[0] = 0;
      if (win == 1) begin mv[1] = 1; mval[1] = ext_fn(r1i, r1s); end
      else if (p1r) mv[1] = 0;
      if (win >= 0) recent = win;
      tick();
      checks++; if (rv0 !== mv[0] || simm0 !== mval[0]) begin errors++;
        $display("FAIL rand_rsp0 cycle %0d got %0b/%h exp %0b/%h", c, rv0, simm0, mv[0], mval[0]); end
      checks++; if (rv1 !== mv[1] || simm1 !== mval[1]) begin errors++;
        $display("FAIL rand_rsp1 cycle %0d got %0b/%h exp %0b/%h", c, rv1, simm1, mv[1], mval[1]); end
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick();
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_drain_refill();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
